// File: rtl/lsnn_pkg.sv
// Shared types, defaults and saturating helper for the LSNN neuron scheduler.
// The neuron record is sized by W_DEF; the scheduler's W must match it.
package lsnn_pkg;

    localparam int unsigned W_DEF     = 8;
    localparam int unsigned B0_DEF    = 8;
    localparam int unsigned ALPHA_DEF = 8;
    localparam int unsigned A_MIN_DEF = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StWr,
        StDone
    } lsnn_state_e;

    typedef struct packed {
        logic [W_DEF-1:0] v;
        logic [W_DEF-1:0] a;
        logic [W_DEF-1:0] thr;
    } neuron_t;

    // Unsigned add clamped to 2^width-1; width must be below 32.
    function automatic logic [31:0] sat_add(input logic [31:0] x, input logic [31:0] y,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, x} + {1'b0, y};
        lim = (33'd1 << width) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lsnn_update_unit.sv
// Combinational adaptive-threshold LIF update for one neuron.
// LSNN_REFRACTORY_EN adds a refractory flag input/output.
module lsnn_update_unit
    import lsnn_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned B0    = B0_DEF,
    parameter int unsigned A_MIN = A_MIN_DEF
) (
`ifdef LSNN_REFRACTORY_EN
    input  logic         refr,
    output logic         refr_next,
`endif
    input  logic [W-1:0] v,
    input  logic [W-1:0] a,
    input  logic [W-1:0] thr,
    input  logic [W-1:0] cur,
    output logic [W-1:0] v_next,
    output logic [W-1:0] a_next,
    output logic [W-1:0] thr_next,
    output logic         spike
);

    logic [W-1:0] v_decay;
    logic [W-1:0] a_up;
    logic [W-1:0] a_dn;
    logic [W-1:0] a_raw;

    always_comb begin
        v_decay = W'(sat_add(32'(cur), 32'(v >> 1), W));
`ifdef LSNN_REFRACTORY_EN
        // A flagged neuron skips its input and cannot fire this step.
        spike     = (v >= thr) && !refr;
        v_next    = refr ? (v >> 1) : (spike ? '0 : v_decay);
        refr_next = spike;
`else
        spike  = (v >= thr);
        v_next = v_decay;
`endif
        a_up     = W'(sat_add(32'(a), 32'(a >> 2), W));
        a_dn     = (a >> 1) + (a >> 2);
        a_raw    = spike ? a_up : a_dn;
        a_next   = (a_raw < W'(A_MIN)) ? W'(A_MIN) : a_raw;
        thr_next = W'(sat_add(32'(B0), 32'(a_next), W));
    end

endmodule

// File: rtl/lsnn_neuron_scheduler.sv
// Sweeps N virtual adaptive-threshold LIF neurons through one shared update unit.
// Optional refractory behaviour is enabled by LSNN_REFRACTORY_EN.
module lsnn_neuron_scheduler
    import lsnn_pkg::*;
#(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned W         = W_DEF,
    parameter int unsigned B0        = B0_DEF,
    parameter int unsigned ALPHA     = ALPHA_DEF,
    parameter int unsigned A_MIN     = A_MIN_DEF,
    localparam int unsigned AW       = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cur_wr_en,
    input  logic [AW-1:0]        cur_wr_addr,
    input  logic [W-1:0]         cur_wr_data,
    input  logic                 step_start,
    output logic                 busy,
    output logic                 step_done,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic [AW-1:0]        thr_rd_addr,
    output logic [W-1:0]         thr_rd_data
);

    lsnn_state_e          state_q;
    logic [AW-1:0]        idx_q;
    logic                 busy_q;
    logic                 step_done_q;
    logic [N_NEURONS-1:0] spike_vec_q;
    logic [N_NEURONS-1:0] spike_acc_q;
    neuron_t              nrn_q     [N_NEURONS];
    logic [W-1:0]         shadow_q  [N_NEURONS];
    logic [W-1:0]         active_q  [N_NEURONS];
    neuron_t              pipe_q;
    logic [W-1:0]         pipe_cur_q;

    logic [W-1:0] v_next;
    logic [W-1:0] a_next;
    logic [W-1:0] thr_next;
    logic         spike;

`ifdef LSNN_REFRACTORY_EN
    logic [N_NEURONS-1:0] refr_q;
    logic                 pipe_refr_q;
    logic                 refr_next;
`endif

    lsnn_update_unit #(
        .W     (W),
        .B0    (B0),
        .A_MIN (A_MIN)
    ) u_update (
`ifdef LSNN_REFRACTORY_EN
        .refr      (pipe_refr_q),
        .refr_next (refr_next),
`endif
        .v         (pipe_q.v),
        .a         (pipe_q.a),
        .thr       (pipe_q.thr),
        .cur       (pipe_cur_q),
        .v_next    (v_next),
        .a_next    (a_next),
        .thr_next  (thr_next),
        .spike     (spike)
    );

    // Reset is asynchronous and asserted while rst_n is high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            step_done_q <= 1'b0;
            spike_vec_q <= '0;
            spike_acc_q <= '0;
            pipe_q      <= '0;
            pipe_cur_q  <= '0;
            for (int i = 0; i < int'(N_NEURONS); i++) begin
                nrn_q[i].v   <= '0;
                nrn_q[i].a   <= W'(ALPHA);
                nrn_q[i].thr <= W'(sat_add(32'(B0), 32'(ALPHA), W));
                shadow_q[i]  <= '0;
                active_q[i]  <= '0;
            end
`ifdef LSNN_REFRACTORY_EN
            refr_q      <= '0;
            pipe_refr_q <= 1'b0;
`endif
        end else begin
            step_done_q <= 1'b0;
            if (cur_wr_en) begin
                shadow_q[cur_wr_addr] <= cur_wr_data;
            end
            unique case (state_q)
                StIdle: begin
                    if (step_start) begin
                        // Snapshot uses pre-write shadow values; a coincident write waits a step.
                        for (int i = 0; i < int'(N_NEURONS); i++) begin
                            active_q[i] <= shadow_q[i];
                        end
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        spike_acc_q <= '0;
                        state_q     <= StRd;
                    end
                end
                StRd: begin
                    pipe_q     <= nrn_q[idx_q];
                    pipe_cur_q <= active_q[idx_q];
`ifdef LSNN_REFRACTORY_EN
                    pipe_refr_q <= refr_q[idx_q];
`endif
                    state_q <= StWr;
                end
                StWr: begin
                    nrn_q[idx_q].v     <= v_next;
                    nrn_q[idx_q].a     <= a_next;
                    nrn_q[idx_q].thr   <= thr_next;
                    spike_acc_q[idx_q] <= spike;
`ifdef LSNN_REFRACTORY_EN
                    refr_q[idx_q] <= refr_next;
`endif
                    if (idx_q == AW'(N_NEURONS - 1)) begin
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StRd;
                    end
                end
                StDone: begin
                    spike_vec_q <= spike_acc_q;
                    step_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign step_done   = step_done_q;
    assign spike_vec   = spike_vec_q;
    assign thr_rd_data = nrn_q[thr_rd_addr].thr;

endmodule

// File: tb/tb_lsnn_neuron_scheduler.sv
// Randomized self-checking bench for lsnn_neuron_scheduler against a per-step behavioural model.
module tb_lsnn_neuron_scheduler;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int B0    = 8;
    localparam int ALPHA = 8;
    localparam int AMIN  = 4;
    localparam int MAXV  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cur_wr_en = 1'b0;
    logic [1:0]   cur_wr_addr = '0;
    logic [W-1:0] cur_wr_data = '0;
    logic         step_start = 1'b0;
    logic         busy;
    logic         step_done;
    logic [N-1:0] spike_vec;
    logic [1:0]   thr_rd_addr = '0;
    logic [W-1:0] thr_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    int m_v[N], m_a[N], m_thr[N], m_sh[N], m_act[N], m_refr[N];
    int m_spk;

    lsnn_neuron_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_wr_en   (cur_wr_en),
        .cur_wr_addr (cur_wr_addr),
        .cur_wr_data (cur_wr_data),
        .step_start  (step_start),
        .busy        (busy),
        .step_done   (step_done),
        .spike_vec   (spike_vec),
        .thr_rd_addr (thr_rd_addr),
        .thr_rd_data (thr_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > MAXV) ? MAXV : x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_a[i] = ALPHA; m_thr[i] = sat(B0 + ALPHA);
            m_sh[i] = 0; m_act[i] = 0; m_refr[i] = 0;
        end
        m_spk = 0;
    endtask

    // One timestep per the neuron equations, applied to every neuron.
    task automatic model_step();
        int s, a_raw;
        m_spk = 0;
        for (int i = 0; i < N; i++) begin
`ifdef LSNN_REFRACTORY_EN
            if (m_refr[i] != 0) begin
                s = 0; m_v[i] = m_v[i] / 2; m_refr[i] = 0;
            end else begin
                s = (m_v[i] >= m_thr[i]) ? 1 : 0;
                m_v[i] = s ? 0 : sat(m_act[i] + m_v[i] / 2);
                m_refr[i] = s;
            end
`else
            s = (m_v[i] >= m_thr[i]) ? 1 : 0;
            m_v[i] = sat(m_act[i] + m_v[i] / 2);
`endif
            a_raw = s ? sat(m_a[i] + m_a[i] / 4) : (m_a[i] / 2 + m_a[i] / 4);
            m_a[i] = (a_raw < AMIN) ? AMIN : a_raw;
            m_thr[i] = sat(B0 + m_a[i]);
            if (s != 0) m_spk |= (1 << i);
        end
    endtask

    task automatic check_thr_all(input string tag);
        for (int i = 0; i < N; i++) begin
            thr_rd_addr = 2'(i);
            #1;
            check_eq(tag, 32'(thr_rd_data), 32'(m_thr[i]));
        end
    endtask

    task automatic do_reset();
        cur_wr_en = 1'b0; step_start = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
    endtask

    task automatic write_cur(input int addr, input int data);
        cur_wr_en = 1'b1; cur_wr_addr = 2'(addr); cur_wr_data = W'(data);
        @(posedge clk);
        m_sh[addr] = data;
        #1 cur_wr_en = 1'b0;
    endtask

    task automatic run_step(input bit noisy);
        int cyc, wa, wd;
        bit got, co_wr, pend;
        co_wr = noisy && ($urandom_range(0, 2) == 0);
        wa = $urandom_range(0, N - 1); wd = $urandom_range(0, MAXV);
        step_start = 1'b1;
        if (co_wr) begin
            cur_wr_en = 1'b1; cur_wr_addr = 2'(wa); cur_wr_data = W'(wd);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
        if (co_wr) m_sh[wa] = wd;
        #1 step_start = 1'b0; cur_wr_en = 1'b0;
        check_eq("busy_run", 32'(busy), 32'd1);
        cyc = 0; got = 1'b0;
        while (!got && cyc < 40) begin
            pend = 1'b0;
            if (noisy && cyc < 7 && $urandom_range(0, 2) == 0) begin
                wa = $urandom_range(0, N - 1); wd = $urandom_range(0, MAXV);
                cur_wr_en = 1'b1; cur_wr_addr = 2'(wa); cur_wr_data = W'(wd); pend = 1'b1;
            end
            if (noisy && cyc < 7 && $urandom_range(0, 3) == 0) step_start = 1'b1;
            @(posedge clk);
            if (pend) m_sh[wa] = wd;
            #1 cur_wr_en = 1'b0; step_start = 1'b0;
            cyc++;
            if (step_done === 1'b1) got = 1'b1;
        end
        check_eq("latency", 32'(cyc), 32'd9);
        model_step();
        check_eq("spike_vec", 32'(spike_vec), 32'(m_spk));
        check_eq("busy_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_eq("done_pulse", 32'(step_done), 32'd0);
        check_eq("spike_hold", 32'(spike_vec), 32'(m_spk));
        check_thr_all("thr");
    endtask

    initial begin
        bit seen;

        // Reset state
        do_reset();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_spike", 32'(spike_vec), 32'd0);
        check_eq("rst_done", 32'(step_done), 32'd0);
        for (int i = 0; i < N; i++) begin
            thr_rd_addr = 2'(i); #1;
            check_eq("rst_thr16", 32'(thr_rd_data), 32'd16);
        end

        // Neuron 0 with I=20: no spike, then spike
        write_cur(0, 20);
        run_step(1'b0);
        thr_rd_addr = 2'd0; #1;
        check_eq("i20_thr0_s1", 32'(thr_rd_data), 32'd14);
        check_eq("i20_spk_s1", 32'(spike_vec[0]), 32'd0);
        run_step(1'b0);
        thr_rd_addr = 2'd0; #1;
        check_eq("i20_thr0_s2", 32'(thr_rd_data), 32'd15);
        check_eq("i20_spk_s2", 32'(spike_vec[0]), 32'd1);

        // No input: adaptation decays to its floor
        do_reset();
        run_step(1'b0);
        thr_rd_addr = 2'd0; #1; check_eq("idle_thr_s1", 32'(thr_rd_data), 32'd14);
        run_step(1'b0);
        thr_rd_addr = 2'd0; #1; check_eq("idle_thr_s2", 32'(thr_rd_data), 32'd12);
        run_step(1'b0);
        thr_rd_addr = 2'd0; #1; check_eq("idle_thr_s3", 32'(thr_rd_data), 32'd12);
        check_eq("idle_spk", 32'(spike_vec), 32'd0);

        // Saturating input on neuron 3
        do_reset();
        write_cur(3, 255);
        repeat (4) run_step(1'b0);

        // Randomized steps with writes and stray starts during the sweep
        do_reset();
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 1) == 0)
                write_cur($urandom_range(0, N - 1), $urandom_range(0, MAXV));
            run_step(1'b1);
        end

        // Reset in the middle of a sweep
        step_start = 1'b1;
        @(posedge clk); #1 step_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(step_done), 32'd0);
        check_eq("midrst_spike", 32'(spike_vec), 32'd0);
        check_thr_all("midrst_thr");
        @(posedge clk); #1 rst_n = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (step_done === 1'b1) seen = 1'b1;
        end
        check_eq("midrst_no_done", 32'(seen), 32'd0);
        check_eq("midrst_idle", 32'(busy), 32'd0);
        check_thr_all("post_rst_thr");

        // A fresh sweep after the aborted one still works
        write_cur(1, 255);
        repeat (3) run_step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
